readout_queue: RTL and testbench

READOUT_QUEUE -- requirements
Module: readout_queue

---
 rtl/readout_queue.sv | 126 ++++++++++++
 tb/tb_readout_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/readout_queue.sv
// rtl/readout_queue.sv - readout entry queue with head-block readout/free handshake
// Define READOUT_QUEUE_DROP_COUNT_EN to add the saturating dropped_o write-drop counter.
module readout_queue #(
   parameter int DEPTH_BITS = 4,
   parameter int N_TRIGGERS = 3,
   localparam int TRIGGER_WIDTH = N_TRIGGERS + 1,
   localparam int W = 15 + 9 + TRIGGER_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wea_i,
   input  logic [W-1:0]          din_i,
   output logic                  event_valid_o,
   output logic [W-1:0]          event_o,
   input  logic                  event_start_i,
   input  logic                  event_complete_i,
   output logic                  readout_done_o,
   output logic [8:0]            free_address_o,
   input  logic                  readout_ack_i,
   output logic [DEPTH_BITS:0]   count_o,
   output logic                  full_o,
   output logic                  empty_o,
`ifdef READOUT_QUEUE_DROP_COUNT_EN
   output logic [7:0]            dropped_o,
`endif
   output logic                  overflow_o
);

   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] FULL_COUNT = {1'b1, {DEPTH_BITS{1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, FREE_WAIT, POP} state_t;

   state_t                state_q, state_d;
   logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_BITS:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  done_q, done_d;
   logic [W-1:0]          mem_q [DEPTH];
   logic                  pop, wr_en, full, empty;

   assign full  = (count_q == FULL_COUNT);
   assign empty = (count_q == '0);

   always_comb begin
      state_d    = state_q;
      done_d     = 1'b0;
      pop        = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      case (state_q)
         IDLE:      if (event_start_i && !empty) state_d = BUSY;
         BUSY:      if (event_complete_i) begin
                       state_d = FREE_WAIT;
                       done_d  = 1'b1;
                    end
         FREE_WAIT: if (readout_ack_i) state_d = POP;
         POP:       begin
                       pop     = 1'b1;
                       state_d = IDLE;
                    end
         default:   state_d = IDLE;
      endcase

      // A pop in the same cycle frees the slot, so a full queue can still take a write.
      wr_en = wea_i && (!full || pop);
      if (wea_i && !wr_en) overflow_d = 1'b1;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !pop)      count_d = count_q + 1'b1;
      else if (!wr_en && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   // Entry storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= din_i;
   end

`ifdef READOUT_QUEUE_DROP_COUNT_EN
   logic [7:0] dropped_q, dropped_d;

   always_comb begin
      dropped_d = dropped_q;
      if (wea_i && !wr_en && dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dropped_q <= '0;
      else          dropped_q <= dropped_d;
   end

   assign dropped_o = dropped_q;
`endif

   assign event_valid_o  = (state_q == IDLE) && !empty;
   assign event_o        = mem_q[rd_ptr_q];
   assign free_address_o = event_o[8:0];
   assign readout_done_o = done_q;
   assign count_o        = count_q;
   assign full_o         = full;
   assign empty_o        = empty;
   assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_readout_queue.sv
// tb/tb_readout_queue.sv - scoreboard bench for readout_queue with a queue-based reference model
module tb_readout_queue;

   localparam int DEPTH_BITS = 4;
   localparam int DEPTH      = 1 << DEPTH_BITS;
   localparam int W          = 28;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                wea_i = 1'b0;
   logic [W-1:0]        din_i = '0;
   logic                event_start_i = 1'b0;
   logic                event_complete_i = 1'b0;
   logic                readout_ack_i = 1'b0;
   logic                event_valid_o;
   logic [W-1:0]        event_o;
   logic                readout_done_o;
   logic [8:0]          free_address_o;
   logic [DEPTH_BITS:0] count_o;
   logic                full_o, empty_o, overflow_o;
`ifdef READOUT_QUEUE_DROP_COUNT_EN
   logic [7:0]          dropped_o;
`endif

   readout_queue #(.DEPTH_BITS(DEPTH_BITS), .N_TRIGGERS(3)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .wea_i            (wea_i),
      .din_i            (din_i),
      .event_valid_o    (event_valid_o),
      .event_o          (event_o),
      .event_start_i    (event_start_i),
      .event_complete_i (event_complete_i),
      .readout_done_o   (readout_done_o),
      .free_address_o   (free_address_o),
      .readout_ack_i    (readout_ack_i),
      .count_o          (count_o),
      .full_o           (full_o),
      .empty_o          (empty_o),
`ifdef READOUT_QUEUE_DROP_COUNT_EN
      .dropped_o        (dropped_o),
`endif
      .overflow_o       (overflow_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   typedef enum {P_IDLE, P_READ, P_FREE, P_POP} phase_t;
   logic [W-1:0] exp_q[$];
   phase_t       phase = P_IDLE;
   bit           done_exp = 1'b0;
   bit           ovf_exp = 1'b0;
   int           drop_exp = 0;
   int           pops = 0;
   int           sz, exp_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor + reference model: inputs are stable at negedge, so they describe the next posedge.
   always @(negedge clk) begin
      if (!reset_n) begin
         check("rst_count", 32'(count_o), 32'd0);
         check("rst_valid", 32'(event_valid_o), 32'd0);
         check("rst_done", 32'(readout_done_o), 32'd0);
         check("rst_empty", 32'(empty_o), 32'd1);
         check("rst_full", 32'(full_o), 32'd0);
         check("rst_overflow", 32'(overflow_o), 32'd0);
         exp_q.delete();
         phase    = P_IDLE;
         done_exp = 1'b0;
         ovf_exp  = 1'b0;
         drop_exp = 0;
      end else begin
         sz      = exp_q.size();
         exp_cnt = sz + ((phase == P_POP) ? 1 : 0);
         check("count", 32'(count_o), 32'(exp_cnt));
         check("empty", 32'(empty_o), 32'(exp_cnt == 0));
         check("full", 32'(full_o), 32'(exp_cnt == DEPTH));
         check("valid", 32'(event_valid_o), 32'(phase == P_IDLE && sz != 0));
         check("done", 32'(readout_done_o), 32'(done_exp));
         check("overflow", 32'(overflow_o), 32'(ovf_exp));
         if (phase != P_POP && sz != 0) begin
            check("event", 32'(event_o), 32'(exp_q[0]));
            check("free_addr", 32'(free_address_o), 32'(exp_q[0][8:0]));
         end
`ifdef READOUT_QUEUE_DROP_COUNT_EN
         check("dropped", 32'(dropped_o), 32'(drop_exp));
`endif
         // During the pop cycle the departing entry is already gone from exp_q.
         if (wea_i) begin
            if (sz < DEPTH) exp_q.push_back(din_i);
            else begin
               ovf_exp = 1'b1;
               if (drop_exp < 255) drop_exp++;
            end
         end
         done_exp = 1'b0;
         case (phase)
            P_IDLE: if (event_start_i && sz != 0) phase = P_READ;
            P_READ: if (event_complete_i) begin
                       phase    = P_FREE;
                       done_exp = 1'b1;
                    end
            P_FREE: if (readout_ack_i) begin
                       void'(exp_q.pop_front());
                       pops++;
                       phase = P_POP;
                    end
            P_POP:  phase = P_IDLE;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input bit w, input logic [W-1:0] d, input bit s, input bit c, input bit a);
      wea_i            = w;
      din_i            = d;
      event_start_i    = s;
      event_complete_i = c;
      readout_ack_i    = a;
      tick();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step(0, '0, 0, 0, 0);
      step(0, '0, 0, 0, 0);
      reset_n = 1'b1;
      step(0, '0, 0, 0, 0);
   endtask

   logic [W-1:0] last_word;

   initial begin
      reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // Single entry becomes head one cycle after the write.
      step(1, 28'h0ABC123, 0, 0, 0);
      check("req033_valid", 32'(event_valid_o), 32'd1);
      check("req033_event", 32'(event_o), 32'h0ABC123);
      check("req033_count", 32'(count_o), 32'd1);
      check("req033_free", 32'(free_address_o), 32'h123);

      // Readout with a delayed ack.
      step(0, '0, 1, 0, 0);
      step(0, '0, 0, 1, 0);
      check("req034_done", 32'(readout_done_o), 32'd1);
      repeat (5) begin
         step(0, '0, 0, 0, 0);
         check("req034_free_stable", 32'(free_address_o), 32'h123);
      end
      step(0, '0, 0, 0, 1);
      check("req034_count_pop", 32'(count_o), 32'd1);
      step(0, '0, 0, 0, 0);
      check("req034_count", 32'(count_o), 32'd0);
      check("req034_empty", 32'(empty_o), 32'd1);

      // Overfill: the 17th write is dropped.
      for (int i = 0; i < 17; i++) step(1, W'($urandom), 0, 0, 0);
      step(0, '0, 0, 0, 0);
      check("req035_count", 32'(count_o), 32'd16);
      check("req035_full", 32'(full_o), 32'd1);
      check("req035_overflow", 32'(overflow_o), 32'd1);
`ifdef READOUT_QUEUE_DROP_COUNT_EN
      check("req035_dropped", 32'(dropped_o), 32'd1);
`endif

      // Full queue with a write landing on the pop cycle.
      do_reset();
      for (int i = 0; i < 16; i++) step(1, W'($urandom), 0, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 0, 1, 0);
      step(0, '0, 0, 0, 1);
      last_word = W'($urandom);
      step(1, last_word, 0, 0, 0);
      check("req036_count", 32'(count_o), 32'd16);
      check("req036_overflow", 32'(overflow_o), 32'd0);

      // Reset while waiting for the free ack.
      do_reset();
      for (int i = 0; i < 3; i++) step(1, W'($urandom), 0, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 0, 1, 0);
      step(0, '0, 0, 0, 0);
      reset_n = 1'b0;
      #1;
      check("req038_count", 32'(count_o), 32'd0);
      check("req038_done", 32'(readout_done_o), 32'd0);
      check("req038_valid", 32'(event_valid_o), 32'd0);
      tick();
      reset_n = 1'b1;
      last_word = W'($urandom);
      step(1, last_word, 0, 0, 0);
      check("req038_event", 32'(event_o), 32'(last_word));

      // Fill, then random traffic crossing many pointer wraps.
      for (int i = 0; i < 15; i++) step(1, W'($urandom), 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) < 50, W'($urandom),
              $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 30,
              $urandom_range(0, 99) < 30);
      end
      step(0, '0, 0, 0, 0);
      check("pops_seen", 32'(pops >= 40), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
